// File: rtl/dual_fetch_queue.sv
// dual_fetch_queue: fetches pc/pc+1 pairs into a DEPTH-entry circular queue and presents up to two in-order insns to decode; define PAIR_HAZARD_EN to hold slot B when it reads slot A's rd
module dual_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int AW = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic [AW-1:0]           address_imem_a,
  output logic [AW-1:0]           address_imem_b,
  output logic                    rden_a,
  output logic                    rden_b,
  input  logic [31:0]             q_imem_a,
  input  logic [31:0]             q_imem_b,
  input  logic                    redirect,
  input  logic [AW-1:0]           redirect_pc,
  output logic                    out_valid_a,
  output logic                    out_valid_b,
  output logic [31:0]             out_insn_a,
  output logic [31:0]             out_insn_b,
  output logic [AW-1:0]           out_pc_a,
  output logic [AW-1:0]           out_pc_b,
  input  logic [1:0]              dec_take,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] pc_q, pc_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_n1, tail_n1;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   insn_q [DEPTH];
  logic [AW-1:0] epc_q [DEPTH];
  logic          fetch_en, hazard;
  logic [1:0]    avail, take;
  always_comb begin
    head_n1 = head_q + PW'(1);
    tail_n1 = tail_q + PW'(1);
    fetch_en = ~reset & ~redirect & (count_q <= CW'(DEPTH - 2));
    address_imem_a = pc_q;
    address_imem_b = pc_q + AW'(1);
    rden_a = fetch_en;
    rden_b = fetch_en;
    out_insn_a = insn_q[head_q];
    out_insn_b = insn_q[head_n1];
    out_pc_a = epc_q[head_q];
    out_pc_b = epc_q[head_n1];
`ifdef PAIR_HAZARD_EN
    hazard = (out_insn_a[31:27] inside {5'b00000, 5'b00101, 5'b01000}) && (out_insn_a[26:22] != 5'd0) &&
             (out_insn_a[26:22] == out_insn_b[21:17] || out_insn_a[26:22] == out_insn_b[16:12]);
`else
    hazard = 1'b0;
`endif
    out_valid_a = count_q != '0;
    out_valid_b = (count_q >= CW'(2)) & ~hazard;
    avail = {1'b0, out_valid_a} + {1'b0, out_valid_b};
    take = dec_take > avail ? avail : dec_take;
    count = count_q;
    pc_d = redirect ? redirect_pc : fetch_en ? pc_q + AW'(2) : pc_q;
    head_d = redirect ? '0 : head_q + PW'(take);
    tail_d = redirect ? '0 : fetch_en ? tail_q + PW'(2) : tail_q;
    count_d = redirect ? '0 : count_q + (fetch_en ? CW'(2) : CW'(0)) - CW'(take);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      pc_q <= pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (fetch_en) begin
      insn_q[tail_q] <= q_imem_a;
      epc_q[tail_q] <= pc_q;
      insn_q[tail_n1] <= q_imem_b;
      epc_q[tail_n1] <= address_imem_b;
    end
  end
endmodule

// File: tb/tb_dual_fetch_queue.sv
// tb_dual_fetch_queue: randomized scoreboard bench for dual_fetch_queue against a queue-based reference model
module tb_dual_fetch_queue;
  localparam int DEPTH = 8;
  localparam int AW = 12;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AMOD = 1 << AW;
`ifdef PAIR_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif
  typedef struct {
    logic [31:0]   insn;
    logic [AW-1:0] pc;
  } ent_t;
  typedef struct {
    int            cnt;
    bit            va;
    bit            vb;
    bit            hb;
    bit            rden;
    logic [31:0]   ia;
    logic [31:0]   ib;
    logic [AW-1:0] pa;
    logic [AW-1:0] pb;
    int            addr;
  } exp_t;
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address_imem_a, address_imem_b;
  logic          rden_a, rden_b;
  logic [31:0]   q_imem_a, q_imem_b;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid_a, out_valid_b;
  logic [31:0]   out_insn_a, out_insn_b;
  logic [AW-1:0] out_pc_a, out_pc_b;
  logic [1:0]    dec_take = 2'd0;
  logic [CW-1:0] count;
  logic [31:0]   imem [AMOD];
  ent_t          mq[$];
  exp_t          sb[$];
  int            mpc = 0;
  int            errors = 0;
  int            checks = 0;
  always #5 clock = ~clock;
  assign q_imem_a = imem[address_imem_a];
  assign q_imem_b = imem[address_imem_b];
  dual_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset),
    .address_imem_a(address_imem_a), .address_imem_b(address_imem_b),
    .rden_a(rden_a), .rden_b(rden_b),
    .q_imem_a(q_imem_a), .q_imem_b(q_imem_b),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid_a(out_valid_a), .out_valid_b(out_valid_b),
    .out_insn_a(out_insn_a), .out_insn_b(out_insn_b),
    .out_pc_a(out_pc_a), .out_pc_b(out_pc_b),
    .dec_take(dec_take), .count(count)
  );
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic bit dep(logic [31:0] a, logic [31:0] b);
    logic [4:0] rd;
    bit writes;
    rd = a[26:22];
    writes = (a[31:27] == 5'd0) || (a[31:27] == 5'd5) || (a[31:27] == 5'd8);
    return writes && rd != 5'd0 && (rd == b[21:17] || rd == b[16:12]);
  endfunction
  task automatic step(input bit rst, input int dt, input bit rd, input int rpc);
    exp_t e;
    bit fetch;
    int n;
    @(posedge clock);
    #1;
    reset = rst;
    dec_take = dt[1:0];
    redirect = rd;
    redirect_pc = rpc[AW-1:0];
    e.cnt = mq.size();
    e.va = mq.size() >= 1;
    e.hb = mq.size() >= 2;
    e.vb = e.hb && !(HZ && dep(mq[0].insn, mq[1].insn));
    e.ia = e.va ? mq[0].insn : '0;
    e.pa = e.va ? mq[0].pc : '0;
    e.ib = e.hb ? mq[1].insn : '0;
    e.pb = e.hb ? mq[1].pc : '0;
    e.addr = mpc;
    fetch = !rst && !rd && (DEPTH - mq.size() >= 2);
    e.rden = fetch;
    sb.push_back(e);
    if (rst) begin
      mq.delete();
      mpc = 0;
    end else if (rd) begin
      mq.delete();
      mpc = rpc % AMOD;
    end else begin
      n = dt;
      if (n > int'(e.va) + int'(e.vb)) n = int'(e.va) + int'(e.vb);
      repeat (n) void'(mq.pop_front());
      if (fetch) begin
        mq.push_back('{insn: imem[mpc], pc: AW'(mpc)});
        mq.push_back('{insn: imem[(mpc + 1) % AMOD], pc: AW'((mpc + 1) % AMOD)});
        mpc = (mpc + 2) % AMOD;
      end
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count", 32'(count), e.cnt);
        chk("valid_a", 32'(out_valid_a), 32'(e.va));
        chk("valid_b", 32'(out_valid_b), 32'(e.vb));
        chk("addr_a", 32'(address_imem_a), e.addr);
        chk("addr_b", 32'(address_imem_b), (e.addr + 1) % AMOD);
        chk("rden_a", 32'(rden_a), 32'(e.rden));
        chk("rden_b", 32'(rden_b), 32'(e.rden));
        if (e.va) begin
          chk("insn_a", out_insn_a, e.ia);
          chk("pc_a", 32'(out_pc_a), 32'(e.pa));
        end
        if (e.hb) begin
          chk("insn_b", out_insn_b, e.ib);
          chk("pc_b", 32'(out_pc_b), 32'(e.pb));
        end
      end
    end
  end
  initial begin
    int hz_dt[10] = '{0, 0, 0, 2, 1, 2, 2, 0, 1, 1};
    for (int k = 0; k < AMOD; k++) imem[k] = (k < 'h400) ? 32'(k) : $urandom;
    imem['h200] = {5'd0, 5'd3, 5'd1, 5'd2, 12'd0};
    imem['h201] = {5'd0, 5'd4, 5'd3, 5'd5, 12'd0};
    imem['h202] = {5'd0, 5'd3, 5'd1, 5'd2, 12'd0};
    imem['h203] = {5'd0, 5'd4, 5'd6, 5'd5, 12'd0};
    imem['h204] = {5'd0, 5'd0, 5'd1, 5'd2, 12'd0};
    imem['h205] = {5'd0, 5'd4, 5'd0, 5'd5, 12'd0};
    repeat (2) step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    step(0, 0, 1, 'h100);
    repeat (10) step(0, 2, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (4) step(0, 3, 0, 0);
    step(0, 0, 1, 'h200);
    foreach (hz_dt[i]) step(0, hz_dt[i], 0, 0);
    step(0, 0, 1, 'hFFE);
    repeat (6) step(0, 1, 0, 0);
    step(1, 2, 1, 'h300);
    repeat (3) step(0, 2, 0, 0);
    repeat (600) begin
      bit r;
      r = $urandom_range(0, 15) == 0;
      step($urandom_range(0, 99) == 0, int'($urandom_range(0, 3)), r, int'($urandom_range(0, AMOD - 1)));
    end
    @(negedge clock);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
